// File: rtl/inv_diffusion_iter.sv
// Iterative inverse of the Ascon linear diffusion layer: L^-1 = prod L^(2^i), one stage per cycle.
// Optional macro INV_DIFF_CHECK_EN adds check_fail_o, a forward-diffusion self check of data_o.
module inv_diffusion_iter (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [4:0][63:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [4:0][63:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
`ifdef INV_DIFF_CHECK_EN
    ,
    output logic             check_fail_o
`endif
);
    localparam int NB_STAGES = 6;
    localparam logic [2:0] LAST_STAGE = 3'(NB_STAGES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [4:0][63:0] work;
    logic [4:0][63:0] stage_out;

    function automatic logic [5:0] rot_base(input int row, input logic second);
        logic [5:0] amt;
        case (row)
            0:       amt = second ? 6'd28 : 6'd19;
            1:       amt = second ? 6'd39 : 6'd61;
            2:       amt = second ? 6'd6  : 6'd1;
            3:       amt = second ? 6'd17 : 6'd10;
            4:       amt = second ? 6'd41 : 6'd7;
            default: amt = 6'd0;
        endcase
        return amt;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] amt);
        logic [127:0] wide;
        wide = {x, x} >> amt;
        return wide[63:0];
    endfunction

    // Stage cnt applies L^(2^cnt); shifting the 6-bit amount drops the wrap, giving (a<<cnt) mod 64.
    always_comb begin
        stage_out = work;
        for (int r = 0; r < 5; r++) begin
            stage_out[r] = work[r]
                         ^ ror64(work[r], rot_base(r, 1'b0) << cnt)
                         ^ ror64(work[r], rot_base(r, 1'b1) << cnt);
        end
    end

`ifdef INV_DIFF_CHECK_EN
    logic [4:0][63:0] accepted;
    logic [4:0][63:0] forward;

    always_comb begin
        forward = '0;
        for (int r = 0; r < 5; r++) begin
            forward[r] = work[r]
                       ^ ror64(work[r], rot_base(r, 1'b0))
                       ^ ror64(work[r], rot_base(r, 1'b1));
        end
    end

    assign check_fail_o = valid_o && (forward != accepted);
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
`ifdef INV_DIFF_CHECK_EN
            accepted <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        work    <= data_i;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        state   <= RUN;
`ifdef INV_DIFF_CHECK_EN
                        accepted <= data_i;
`endif
                    end
                end
                RUN: begin
                    work <= stage_out;
                    cnt  <= cnt + 3'd1;
                    if (cnt == LAST_STAGE) begin
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign data_o = work;

endmodule

// File: tb/tb_inv_diffusion_iter.sv
// Directed and round-trip bench for inv_diffusion_iter; build with INV_DIFF_CHECK_EN to also watch check_fail_o.
module tb_inv_diffusion_iter;
    typedef logic [4:0][63:0] state_t;

    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic   clock_i = 1'b0;
    logic   reset_i;
    state_t data_i;
    logic   valid_i;
    logic   ready_o;
    state_t data_o;
    logic   valid_o;
    logic   ready_i;
`ifdef INV_DIFF_CHECK_EN
    logic   check_fail_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    inv_diffusion_iter dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
`ifdef INV_DIFF_CHECK_EN
        ,
        .check_fail_o (check_fail_o)
`endif
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] wide;
        wide = {x, x} >> n;
        return wide[63:0];
    endfunction

    function automatic state_t forward(input state_t x);
        state_t y;
        for (int r = 0; r < 5; r++) y[r] = x[r] ^ ror(x[r], ROT_A[r]) ^ ror(x[r], ROT_B[r]);
        return y;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int waited = 0;
        while (!ready_o && waited < 20) begin
            @(posedge clock_i);
            @(negedge clock_i);
            waited++;
        end
        if (!ready_o) checkOutput({tag, "_ready_timeout"}, ready_o, 1);
    endtask

    // Full transaction: accept, count edges to valid_o, check result, release and confirm return to IDLE.
    task automatic applyStimulus(input string tag, input state_t stim, input state_t expected);
        int cycles = 0;
        waitReady(tag);
        data_i  = stim;
        valid_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        valid_i = 1'b0;
        data_i  = '1;
        checkOutput({tag, "_busy"}, ready_o, 0);
        while (!valid_o && cycles < 20) begin
            @(posedge clock_i);
            @(negedge clock_i);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 6);
        checkOutput({tag, "_data"}, data_o, expected);
`ifdef INV_DIFF_CHECK_EN
        checkOutput({tag, "_check_fail"}, check_fail_o, 0);
`endif
        ready_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        ready_i = 1'b0;
        checkOutput({tag, "_idle"}, {ready_o, valid_o}, 2'b10);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        state_t unit_in, unit_out, rows_in, x, held;
        state_t b2b_x [4];
        int     cycles, in_idx, out_idx, last_acc;
        logic   acc, done;

        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        #12;
        checkOutput("reset_ready", ready_o, 1);
        checkOutput("reset_valid", valid_o, 0);
        checkOutput("reset_data", data_o, 0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Hand-computed: L(e0) per row is 1 ^ ror(1,a) ^ ror(1,b)
        unit_in  = '0;
        unit_in[0] = 64'h0000_2010_0000_0001;
        unit_out = '0;
        unit_out[0] = 64'h0000_0000_0000_0001;
        applyStimulus("unit", unit_in, unit_out);

        rows_in[0] = 64'h0000_2010_0000_0001;
        rows_in[1] = 64'h0000_0000_0200_0009;
        rows_in[2] = 64'h8400_0000_0000_0001;
        rows_in[3] = 64'h0040_8000_0000_0001;
        rows_in[4] = 64'h0200_0000_0080_0001;
        for (int r = 0; r < 5; r++) unit_out[r] = 64'h1;
        applyStimulus("rows", rows_in, unit_out);

        applyStimulus("zeros", '0, '0);
        applyStimulus("ones", '1, '1);

        for (int n = 0; n < 1000; n++) begin
            x = rand_state();
            applyStimulus("roundtrip", forward(x), x);
        end

        // Back-pressure: result must hold while stray valid_i pulses are ignored
        held = rand_state();
        waitReady("bp");
        data_i  = forward(held);
        valid_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        valid_i = 1'b0;
        cycles = 0;
        while (!valid_o && cycles < 20) begin
            @(posedge clock_i);
            @(negedge clock_i);
            cycles++;
        end
        checkOutput("bp_latency", cycles, 6);
        for (int k = 0; k < 20; k++) begin
            valid_i = (k % 3 == 0);
            data_i  = rand_state();
            @(posedge clock_i);
            @(negedge clock_i);
            checkOutput("bp_valid", valid_o, 1);
            checkOutput("bp_data", data_o, held);
            checkOutput("bp_ready", ready_o, 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        ready_i = 1'b0;
        checkOutput("bp_release", {ready_o, valid_o}, 2'b10);
        repeat (10) @(posedge clock_i);
        @(negedge clock_i);
        checkOutput("bp_no_stray", {ready_o, valid_o}, 2'b10);

        // Asynchronous reset in the middle of RUN
        waitReady("rst");
        data_i  = forward(rand_state());
        valid_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("midrun_ready", ready_o, 1);
        checkOutput("midrun_valid", valid_o, 0);
        checkOutput("midrun_data", data_o, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock_i);
            @(negedge clock_i);
            checkOutput("midrun_no_output", valid_o, 0);
        end
        ready_i = 1'b0;

        // Back-to-back: valid_i and ready_i held high, accepts every 8 cycles
        for (int k = 0; k < 4; k++) b2b_x[k] = rand_state();
        in_idx   = 0;
        out_idx  = 0;
        last_acc = -1;
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        data_i   = forward(b2b_x[0]);
        for (int cyc = 0; cyc < 100 && out_idx < 4; cyc++) begin
            acc  = ready_o && valid_i;
            done = valid_o && ready_i;
            if (done) begin
                checkOutput("b2b_data", data_o, b2b_x[out_idx]);
                out_idx++;
            end
            if (acc) begin
                if (last_acc >= 0) checkOutput("b2b_gap", cyc - last_acc, 8);
                last_acc = cyc;
                in_idx++;
            end
            @(posedge clock_i);
            @(negedge clock_i);
            if (acc) begin
                if (in_idx < 4) data_i = forward(b2b_x[in_idx]);
                else valid_i = 1'b0;
            end
        end
        checkOutput("b2b_count", out_idx, 4);
        valid_i = 1'b0;
        ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
